// File: rtl/dct2d_sequencer.sv
// Sequencer that computes an 8x8 2-D DCT with one combinational 8-point 1-D core:
// a row pass into a transpose buffer, then a column pass streamed out column-major.
module dct2d_sequencer #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_data,
   output logic [8*N-1:0] core_in,
   input  logic [8*N-1:0] core_out,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   out_data,
   output logic           out_last,
   output logic           busy
);

   localparam logic [2:0] S_LOAD = 3'd0;
   localparam logic [2:0] S_RDRV = 3'd1;
   localparam logic [2:0] S_RCAP = 3'd2;
   localparam logic [2:0] S_CDRV = 3'd3;
   localparam logic [2:0] S_CCAP = 3'd4;
   localparam logic [2:0] S_EMIT = 3'd5;

   logic [2:0]   state;
   logic [2:0]   row;
   logic [2:0]   col;
   logic [2:0]   idx;
   logic [N-1:0] row_reg [8];
   logic [N-1:0] t       [8][8];
   logic [N-1:0] col_reg [8];

   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_LOAD;
         row     <= '0;
         col     <= '0;
         idx     <= '0;
         core_in <= '0;
         // NOTE: the transpose buffer is cleared with everything else so a block
         // aborted by reset can never leak half-written rows into a later block.
         for (int r = 0; r < 8; r++) begin
            row_reg[r] <= '0;
            col_reg[r] <= '0;
            for (int k = 0; k < 8; k++) t[r][k] <= '0;
         end
      end else begin
         // NOTE: all state here uses non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         case (state)
            S_LOAD: begin
               if (in_fire) begin
                  row_reg[idx] <= in_data;
                  if (idx == 3'd7) begin
                     idx   <= '0;
                     state <= S_RDRV;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            S_RDRV: begin
               for (int k = 0; k < 8; k++) core_in[(8-k)*N-1 -: N] <= row_reg[k];
               state <= S_RCAP;
            end
            S_RCAP: begin
               for (int k = 0; k < 8; k++) t[row][k] <= core_out[(8-k)*N-1 -: N];
               if (row == 3'd7) begin
                  row   <= '0;
                  col   <= '0;
                  state <= S_CDRV;
               end else begin
                  row   <= row + 3'd1;
                  state <= S_LOAD;
               end
            end
            S_CDRV: begin
               // Column read of the transpose buffer: element k comes from row k.
               for (int k = 0; k < 8; k++) core_in[(8-k)*N-1 -: N] <= t[k][col];
               state <= S_CCAP;
            end
            S_CCAP: begin
               for (int k = 0; k < 8; k++) col_reg[k] <= core_out[(8-k)*N-1 -: N];
               idx   <= '0;
               state <= S_EMIT;
            end
            S_EMIT: begin
               if (out_fire) begin
                  if (idx == 3'd7) begin
                     idx <= '0;
                     if (col == 3'd7) begin
                        col   <= '0;
                        state <= S_LOAD;
                     end else begin
                        col   <= col + 3'd1;
                        state <= S_CDRV;
                     end
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

   // NOTE: outputs are continuous assignments from registered state, so there is
   // no incomplete-branch combinational process that could infer a latch.
   assign in_ready  = (state == S_LOAD) & ~reset;
   assign out_valid = (state == S_EMIT);
   assign out_data  = out_valid ? col_reg[idx] : '0;
   assign out_last  = out_valid & (col == 3'd7) & (idx == 3'd7);
   assign busy      = (state != S_LOAD) | (row != 3'd0) | (idx != 3'd0);

endmodule

// File: tb/tb_dct2d_sequencer.sv
// Bench for dct2d_sequencer: stub 1-D core (identity or a mixing map) and a
// matrix-level reference of the row/column passes with column-major output order.
module tb_dct2d_sequencer;

   typedef logic [15:0] vec8_t  [8];
   typedef logic [15:0] vec64_t [64];

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [15:0]  in_data;
   logic [127:0] core_in;
   logic [127:0] core_out;
   logic         out_valid;
   logic         out_ready;
   logic [15:0]  out_data;
   logic         out_last;
   logic         busy;
   bit           mix_mode;

   int vectors;
   int miscompares;

   dct2d_sequencer #(.N(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .core_in   (core_in),
      .core_out  (core_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in 1-D core: identity, or y[k] = a[k] + 3*a[k+1 mod 8] + k (mod 2^16).
   function automatic vec8_t core_model(vec8_t a, bit mix);
      vec8_t y;
      for (int k = 0; k < 8; k++)
         y[k] = mix ? 16'(a[k] + 16'd3 * a[(k + 1) % 8] + 16'(k)) : a[k];
      return y;
   endfunction

   function automatic logic [127:0] pack8(vec8_t a);
      logic [127:0] p;
      for (int k = 0; k < 8; k++) p[(8-k)*16-1 -: 16] = a[k];
      return p;
   endfunction

   vec8_t stub_a;
   vec8_t stub_y;
   always_comb begin
      for (int k = 0; k < 8; k++) stub_a[k] = core_in[(8-k)*16-1 -: 16];
      stub_y   = core_model(stub_a, mix_mode);
      core_out = pack8(stub_y);
   end

   // Reference: 1-D transform of each row, then of each column; emit column by column.
   function automatic vec64_t model(vec64_t x, bit mix);
      vec8_t       v;
      vec8_t       w;
      logic [15:0] rows [8][8];
      vec64_t      y;
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 8; k++) v[k] = x[8*r + k];
         w = core_model(v, mix);
         for (int k = 0; k < 8; k++) rows[r][k] = w[k];
      end
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < 8; k++) v[k] = rows[k][c];
         w = core_model(v, mix);
         for (int k = 0; k < 8; k++) y[8*c + k] = w[k];
      end
      return y;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Streams one block and checks every output beat. gap: in_valid on even cycles
   // only; rnd: random in_valid/out_ready; beat stall_at is held off for stall_len
   // cycles; the run stops once abort_at beats were accepted. span = first input
   // accept to last output accept, inclusive.
   task automatic run_block(input vec64_t x, input bit gap, input bit rnd,
                            input int stall_at, input int stall_len,
                            input int abort_at, output int span);
      vec64_t exp_y;
      vec8_t  row0;
      int     sent;
      int     beat;
      int     cyc;
      int     first;
      int     last;
      int     stall_left;
      int     pack_cd;
      bit     done;
      exp_y      = model(x, mix_mode);
      for (int k = 0; k < 8; k++) row0[k] = x[k];
      sent       = 0;
      beat       = 0;
      cyc        = 0;
      first      = -1;
      last       = -1;
      stall_left = stall_len;
      pack_cd    = -1;
      done       = 1'b0;
      while (!done && cyc < 3000) begin
         @(negedge clk);
         if (pack_cd > 0) begin
            pack_cd--;
            if (pack_cd == 0) check("core_in_row0_pack", core_in, pack8(row0));
         end
         in_valid = gap ? (cyc % 2 == 0) : (rnd ? 1'($urandom) : 1'b1);
         in_data  = (sent < 64) ? x[sent] : 16'hDEAD;
         if (beat == stall_at && stall_left > 0) out_ready = 1'b0;
         else out_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
         #1;
         if (sent > 0) check("busy_mid_block", busy, 1'b1);
         if (beat == stall_at && stall_left > 0) begin
            check("stall_valid_held", out_valid, 1'b1);
            check("stall_data_held", out_data, exp_y[beat]);
            stall_left--;
         end
         if (in_valid && in_ready) begin
            check("no_extra_sample", (sent < 64), 1'b1);
            if (first < 0) first = cyc;
            sent++;
            if (sent == 8) pack_cd = 2;
         end
         if (out_valid && out_ready) begin
            check($sformatf("out_data[%0d]", beat), out_data, exp_y[beat]);
            check($sformatf("out_last[%0d]", beat), out_last, (beat == 63));
            last = cyc;
            beat++;
            if (beat == abort_at) done = 1'b1;
         end
         @(posedge clk);
         cyc++;
      end
      if (!done) check("block_timeout_beats", beat, abort_at);
      span = last - first + 1;
      if (done && abort_at == 64) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         check("idle_busy", busy, 1'b0);
         check("idle_out_valid", out_valid, 1'b0);
         check("idle_in_ready", in_ready, 1'b1);
      end
   endtask

   vec64_t ramp;
   vec64_t rnd_x;
   int     span;

   initial begin
      vectors     = 0;
      miscompares = 0;
      mix_mode    = 1'b0;
      reset       = 1'b1;
      in_valid    = 1'b1;
      in_data     = 16'h5555;
      out_ready   = 1'b1;
      for (int i = 0; i < 64; i++) ramp[i] = 16'(i);

      // Reset held 3 cycles with in_valid asserted.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_core_in", core_in, 128'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_out_data", out_data, 16'd0);
      check("rst_out_last", out_last, 1'b0);
      reset    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1'b1);
      check("post_rst_busy", busy, 1'b0);

      // Identity core, ramp input, no stalls: transposed ramp in 160 cycles.
      run_block(ramp, 1'b0, 1'b0, -1, 0, 64, span);
      check("span_continuous", span, 160);

      // Five-cycle hold on column 2 beat 3 (value 26) delays completion by 5.
      run_block(ramp, 1'b0, 1'b0, 19, 5, 64, span);
      check("span_backpressure", span, 165);

      // in_valid on alternate cycles: each row costs 18 cycles instead of 10.
      run_block(ramp, 1'b1, 1'b0, -1, 0, 64, span);
      check("span_gapped_input", span, 223);

      // Mixing core with random data and random handshakes.
      mix_mode = 1'b1;
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 64; i++) rnd_x[i] = 16'($urandom);
         run_block(rnd_x, 1'b0, 1'b1, -1, 0, 64, span);
      end

      // Reset while column 4 is being emitted, then a fresh block.
      for (int i = 0; i < 64; i++) rnd_x[i] = 16'($urandom);
      run_block(rnd_x, 1'b0, 1'b0, -1, 0, 34, span);
      @(negedge clk);
      check("pre_abort_out_valid", out_valid, 1'b1);
      reset    = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_in_ready", in_ready, 1'b0);
      check("abort_busy", busy, 1'b0);
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("abort_release_in_ready", in_ready, 1'b1);
      mix_mode = 1'b0;
      for (int i = 0; i < 64; i++) rnd_x[i] = 16'(100 + i);
      run_block(rnd_x, 1'b0, 1'b0, -1, 0, 64, span);
      check("span_after_abort", span, 160);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dct2d_sequencer.md
Name: dct2d_sequencer

Overview:
- Controller that computes an 8x8 2-D DCT by reusing one combinational 8-point 1-D DCT core twice: first on rows, then on columns.
- Accepts 64 samples serially in raster order over a valid/ready stream.
- Drives the core's packed input, captures the core's packed output into a transpose buffer, then runs the column pass.
- Emits 64 coefficients serially on a valid/ready output stream.

Parameters:
- N, 16, sample/coefficient width in bits; matches the core's per-element width.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept a sample
- in_data  in  N  input sample, raster order (row 0 col 0 first)
- core_in  out  8N  packed vector to 1-D core; element k at [(8-k)*N-1 -: N] (element 0 in the MSBs)
- core_out  in  8N  packed result from 1-D core; coefficient k at [(8-k)*N-1 -: N]
- out_valid  out  1  output coefficient valid
- out_ready  in  1  downstream accepts coefficient
- out_data  out  N  output coefficient
- out_last  out  1  high with the 64th coefficient of a block
- busy  out  1  high from first accepted sample until last output beat accepted

Behaviour:
- Synchronous active-high reset, all registers. State goes to S_LOAD with row=0, col=0, idx=0.
- Reset values: in_ready=0 (gated by reset), core_in=0, out_valid=0, out_data=0, out_last=0, busy=0.
- States and transitions:
  - S_LOAD: in_ready=1. Each in_valid&in_ready beat writes row_reg[idx] and increments idx. On idx=7 accept -> S_RDRV with idx=0.
  - S_RDRV (1 cycle): core_in <= row_reg packed; in_ready=0. -> S_RCAP.
  - S_RCAP (1 cycle): T[row][k] <= core_out element k, k=0..7. If row=7 -> S_CDRV with row=0, col=0; else row++ and -> S_LOAD.
  - S_CDRV (1 cycle): core_in <= {T[0][col],...,T[7][col]}, element k = T[k][col]. -> S_CCAP.
  - S_CCAP (1 cycle): col_reg[k] <= core_out element k. -> S_EMIT with idx=0.
  - S_EMIT: out_valid=1, out_data=col_reg[idx]. Advance idx only on out_valid&out_ready. On accept with idx=7: if col=7 -> S_LOAD (block done, busy falls); else col++ and -> S_CDRV.
- Core latency: the core is combinational. core_out is sampled exactly one cycle after core_in is registered, so a full-period path is allowed.
- Output order: for col 0..7, coefficients k=0..7 of that column, i.e. Y[k][col] emitted column-major.
- out_last=1 only when state=S_EMIT, col=7, idx=7.
- Throughput with no stalls: 10 cycles per row + 10 per column = 160 cycles per block. There is no overlap between blocks; in_ready=0 outside S_LOAD.
- Handshake rules:
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without an accept.
  - in_valid during non-S_LOAD states is ignored.
- Arithmetic: the sequencer only moves data. Values pass bit-exact, N bits, no rounding/saturation.
- T buffer: 64 x N registers. Rows written only in S_RCAP, read only in S_CDRV.
- Reset mid-block: partial block discarded. The cycle after reset deasserts, the block is in S_LOAD with in_ready=1 and out_valid=0, and stale T contents are never emitted.
- busy = (state != S_LOAD) | (row != 0) | (idx != 0).

Test Plan:
- Reset: hold reset 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, core_in=0, busy=0; one cycle after release in_ready=1, no sample accepted during reset.
- Packing: identity stub core, row 0 = 0..7 -> in S_RDRV core_in[127:112]=0 and core_in[15:0]=7 (N=16).
- Full block, identity stub, inputs 0..63 continuous, out_ready=1 -> output sequence 0,8,16,...,56,1,9,...,63; out_last only on 63; 160 cycles from first accept to last accept.
- Backpressure: out_ready=0 for 5 cycles at column 2, beat 3 (value 26 with identity stub) -> out_data stays 26, out_valid stays 1, no beat lost or duplicated, completion delayed by exactly 5 cycles.
- Input gaps and ignored input: in_valid toggling every cycle gives same outputs, each row load taking 16 cycles; in_valid held high during S_RDRV/S_CDRV/S_EMIT gives no extra samples consumed.
- Reset mid-operation: assert reset during S_EMIT of column 4 -> next cycle out_valid=0, then in_ready=1. A fresh block of inputs 100..163 produces the correct transposed sequence starting 100,108.
